// File: rtl/boot_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg
// Shared definitions for the boot sequencer: sequencer state encoding (also
// driven out on the mode port), program-loader state codes, counter widths
// and default parameter values, plus a saturating increment helper.
// -----------------------------------------------------------------------------
package boot_pkg;

   // Sequencer states; the numeric value is what appears on the mode output.
   typedef enum logic [2:0] {
      ST_RUN        = 3'd0,
      ST_HALT       = 3'd1,
      ST_LOAD       = 3'd2,
      ST_HOLD_RESET = 3'd3,
      ST_FAULT      = 3'd4
   } boot_state_e;

   // Program loader state codes seen on loader_state.
   localparam logic [2:0] LDR_WAITING_START_CODE     = 3'd0;
   localparam logic [2:0] LDR_SENDING_START_ACK      = 3'd1;
   localparam logic [2:0] LDR_WAITING_DATA           = 3'd2;
   localparam logic [2:0] LDR_SENDING_COMPLETION_ACK = 3'd3;
   localparam logic [2:0] LDR_FINISHED               = 3'd4;
   localparam logic [2:0] LDR_SENDING_ERROR          = 3'd5;
   localparam logic [2:0] LDR_ERROR                  = 3'd6;

   // Default parameter values (TIMEOUT is 1 s at 12.5 MHz).
   localparam int unsigned DEF_RESET_HOLD_CYCLES = 16;
   localparam int unsigned DEF_TIMEOUT_CYCLES    = 12_500_000;

   // Counter widths.
   localparam int unsigned TIMEOUT_CNT_W = 24;
   localparam int unsigned HOLD_CNT_W    = 16;
   localparam int unsigned WORD_CNT_W    = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [WORD_CNT_W-1:0] sat_inc16(input logic [WORD_CNT_W-1:0] v);
      logic [WORD_CNT_W-1:0] r;
      if (v == 16'hFFFF) begin
         r = v;
      end else begin
         r = v + 16'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/boot_sequencer_if.sv
// -----------------------------------------------------------------------------
// boot_sequencer_if
// Bundles every non-clock/reset signal of the boot sequencer.
//   Inputs to the sequencer : load_request, loader_state, loader_wr,
//                             loader_addr, loader_data, cpu_pc
//   Outputs of the sequencer: loader_enable, cpu_reset, imem_addr, imem_wr,
//                             imem_wdata, mode, error, word_count
// master = the sequencer side, slave = the surrounding system (CPU/loader/imem).
// -----------------------------------------------------------------------------
interface boot_sequencer_if;
   import boot_pkg::*;

   logic                     load_request;
   logic [2:0]               loader_state;
   logic                     loader_wr;
   logic [31:0]              loader_addr;
   logic [31:0]              loader_data;
   logic [31:0]              cpu_pc;

   logic                     loader_enable;
   logic                     cpu_reset;
   logic [31:0]              imem_addr;
   logic                     imem_wr;
   logic [31:0]              imem_wdata;
   logic [2:0]               mode;
   logic                     error;
   logic [WORD_CNT_W-1:0]    word_count;

   modport master (
      input  load_request, loader_state, loader_wr, loader_addr, loader_data, cpu_pc,
      output loader_enable, cpu_reset, imem_addr, imem_wr, imem_wdata, mode, error, word_count
   );

   modport slave (
      output load_request, loader_state, loader_wr, loader_addr, loader_data, cpu_pc,
      input  loader_enable, cpu_reset, imem_addr, imem_wr, imem_wdata, mode, error, word_count
   );
endinterface

// File: rtl/boot_sequencer_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer for an asynchronous level followed by an edge
// register; rise_pulse is high for one cycle after a synchronized 0->1.
//   clock      in  system clock
//   reset      in  asynchronous active-high reset (clears all flops)
//   async_in   in  asynchronous level input
//   rise_pulse out one-cycle pulse on a synchronized rising edge
// -----------------------------------------------------------------------------
module sync_edge
   import boot_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic rise_pulse
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   // Next values of the synchronizer chain and edge register.
   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   // Synchronizer and edge registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/boot_sequencer.sv
// -----------------------------------------------------------------------------
// boot_sequencer
// Controls CPU reset and instruction-memory ownership while a program loader
// writes a new image. A rising edge on load_request (honoured in RUN or FAULT)
// halts the CPU, hands the imem port to the loader, and ends in either a
// timed CPU reset hold (successful load) or FAULT (loader error / timeout).
//   clock  in  system clock (12.5 MHz)
//   reset  in  asynchronous active-high reset
//   bus    boot_sequencer_if.master: loader handshake, CPU fetch address,
//          muxed imem write port, mode / error / word_count status
// Outputs are decoded from the state register so that the LOAD pass-through
// and the asynchronous reset both act in the same cycle.
// -----------------------------------------------------------------------------
module boot_sequencer
   import boot_pkg::*;
#(
   parameter int unsigned RESET_HOLD_CYCLES = DEF_RESET_HOLD_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
   input  logic              clock,
   input  logic              reset,
   boot_sequencer_if.master  bus
);

   // Last count value of each counter before it triggers its transition.
   localparam logic [HOLD_CNT_W-1:0]    HOLD_LAST = HOLD_CNT_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [TIMEOUT_CNT_W-1:0] TMO_LAST  = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

   boot_state_e              state_q, state_d;
   logic [HOLD_CNT_W-1:0]    hold_q, hold_d;
   logic [TIMEOUT_CNT_W-1:0] tmo_q, tmo_d;
   logic [WORD_CNT_W-1:0]    word_count_q, word_count_d;

   logic                     req_pulse;
   logic                     ldr_idle;
   logic                     tmo_hit;

   logic                     cpu_reset_s;
   logic                     loader_enable_s;
   logic [31:0]              imem_addr_s;
   logic                     imem_wr_s;
   logic [31:0]              imem_wdata_s;
   logic                     error_s;

   sync_edge u_sync_edge (
      .clock      (clock),
      .reset      (reset),
      .async_in   (bus.load_request),
      .rise_pulse (req_pulse)
   );

   // Idle-wait detection: the loader is waiting for data and nothing is written.
   always_comb begin
      ldr_idle = 1'b0;
      tmo_hit  = 1'b0;
      if ((state_q == ST_LOAD) && (bus.loader_state == LDR_WAITING_DATA) && !bus.loader_wr) begin
         ldr_idle = 1'b1;
         tmo_hit  = (tmo_q == TMO_LAST);
      end else begin
         ldr_idle = 1'b0;
         tmo_hit  = 1'b0;
      end
   end

   // Next-state, counter and word-count logic.
   always_comb begin
      state_d      = state_q;
      hold_d       = 16'd0;
      tmo_d        = 24'd0;
      word_count_d = word_count_q;

      case (state_q)
         ST_RUN: begin
            if (req_pulse) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_RUN;
            end
         end

         ST_HALT: begin
            state_d = ST_LOAD;
         end

         ST_LOAD: begin
            if (bus.loader_wr) begin
               word_count_d = sat_inc16(word_count_q);
            end else begin
               word_count_d = word_count_q;
            end

            if (ldr_idle) begin
               tmo_d = tmo_q + 24'd1;
            end else begin
               tmo_d = 24'd0;
            end

            // FINISHED is checked first so a simultaneous timeout loses.
            if (bus.loader_state == LDR_FINISHED) begin
               state_d = ST_HOLD_RESET;
            end else if ((bus.loader_state == LDR_ERROR) || tmo_hit) begin
               state_d = ST_FAULT;
            end else begin
               state_d = ST_LOAD;
            end
         end

         ST_HOLD_RESET: begin
            if (hold_q == HOLD_LAST) begin
               state_d = ST_RUN;
            end else begin
               hold_d  = hold_q + 16'd1;
               state_d = ST_HOLD_RESET;
            end
         end

         ST_FAULT: begin
            if (req_pulse) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_FAULT;
            end
         end

         default: begin
            state_d = ST_HOLD_RESET;
         end
      endcase

      // A new load starts its word count from zero on entry to HALT.
      if (state_d == ST_HALT) begin
         word_count_d = 16'd0;
      end else begin
         word_count_d = word_count_d;
      end
   end

   // State, counter and word-count registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_HOLD_RESET;
         hold_q       <= 16'd0;
         tmo_q        <= 24'd0;
         word_count_q <= 16'd0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         tmo_q        <= tmo_d;
         word_count_q <= word_count_d;
      end
   end

   // Output decode; defaults keep the CPU in reset with writes blocked.
   always_comb begin
      cpu_reset_s     = 1'b1;
      loader_enable_s = 1'b0;
      imem_addr_s     = bus.cpu_pc;
      imem_wr_s       = 1'b0;
      imem_wdata_s    = 32'd0;
      error_s         = 1'b0;

      case (state_q)
         ST_RUN: begin
            cpu_reset_s = 1'b0;
         end

         ST_HALT: begin
            // Port already points at the loader; writes stay off until LOAD.
            imem_addr_s  = bus.loader_addr;
            imem_wdata_s = bus.loader_data;
         end

         ST_LOAD: begin
            loader_enable_s = 1'b1;
            imem_addr_s     = bus.loader_addr;
            imem_wdata_s    = bus.loader_data;
            imem_wr_s       = bus.loader_wr;
         end

         ST_HOLD_RESET: begin
            cpu_reset_s = 1'b1;
         end

         ST_FAULT: begin
            error_s = 1'b1;
         end

         default: begin
            cpu_reset_s = 1'b1;
         end
      endcase
   end

   assign bus.cpu_reset     = cpu_reset_s;
   assign bus.loader_enable = loader_enable_s;
   assign bus.imem_addr     = imem_addr_s;
   assign bus.imem_wr       = imem_wr_s;
   assign bus.imem_wdata    = imem_wdata_s;
   assign bus.error         = error_s;
   assign bus.mode          = state_q;
   assign bus.word_count    = word_count_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_boot_sequencer
// Randomized self-checking bench for boot_sequencer. Expected values come from
// the behavioural rules: request latency, one-cycle HALT, pass-through writes
// in LOAD, a running write tally, fixed reset-hold length and timeout length.
// -----------------------------------------------------------------------------
module tb_boot_sequencer;

   localparam logic [2:0] M_RUN   = 3'd0;
   localparam logic [2:0] M_HALT  = 3'd1;
   localparam logic [2:0] M_LOAD  = 3'd2;
   localparam logic [2:0] M_HOLD  = 3'd3;
   localparam logic [2:0] M_FAULT = 3'd4;
   localparam int         HOLD_N  = 16;
   localparam int         TMO_N   = 100;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   exp_words = 0;

   boot_sequencer_if bus ();

   boot_sequencer #(
      .RESET_HOLD_CYCLES (HOLD_N),
      .TIMEOUT_CYCLES    (TMO_N)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // Raise load_request and expect HALT three edges later, then LOAD.
   task automatic request_to_load(input string tag);
      int n = 0;
      bus.load_request = 1'b1;
      while (bus.mode !== M_HALT && n < 10) begin
         tick();
         n++;
      end
      check_val({tag, "_halt_latency"}, n, 3);
      #1;
      check_val({tag, "_halt_cpu_reset"}, bus.cpu_reset, 1);
      check_val({tag, "_halt_ldr_en"}, bus.loader_enable, 0);
      check_val({tag, "_halt_wr"}, bus.imem_wr, 0);
      check_val({tag, "_halt_addr"}, bus.imem_addr, bus.loader_addr);
      check_val({tag, "_halt_error"}, bus.error, 0);
      check_val({tag, "_halt_words"}, bus.word_count, 0);
      exp_words = 0;
      bus.load_request = 1'b0;
      tick();
      check_val({tag, "_load_mode"}, bus.mode, M_LOAD);
      check_val({tag, "_load_ldr_en"}, bus.loader_enable, 1);
   endtask

   // Issue n writes with random idle gaps, checking the same-cycle pass-through.
   task automatic do_writes(input string tag, input int n, input bit directed);
      for (int i = 0; i < n; i++) begin
         int gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            bus.loader_state = 3'($urandom_range(0, 3));
            bus.loader_wr    = 1'b0;
            tick();
         end
         bus.loader_state = 3'd2;
         bus.loader_wr    = 1'b1;
         if (directed && i == 0) begin
            bus.loader_addr = 32'h0000_0000;
            bus.loader_data = 32'h2008_0005;
         end else begin
            bus.loader_addr = $urandom;
            bus.loader_data = $urandom;
         end
         #1;
         check_val({tag, "_wr"}, bus.imem_wr, 1);
         check_val({tag, "_addr"}, bus.imem_addr, bus.loader_addr);
         check_val({tag, "_wdata"}, bus.imem_wdata, bus.loader_data);
         tick();
         exp_words++;
      end
      bus.loader_wr = 1'b0;
      #1;
      check_val({tag, "_word_count"}, bus.word_count, exp_words);
      check_val({tag, "_still_load"}, bus.mode, M_LOAD);
   endtask

   // Count cycles with cpu_reset high, optionally raising a request mid-hold.
   task automatic wait_hold(input string tag, input bit inject_req);
      int n = 0;
      while (bus.cpu_reset === 1'b1 && n < 64) begin
         if (inject_req && n == 2) begin
            bus.load_request = 1'b1;
         end
         tick();
         n++;
      end
      check_val({tag, "_hold_len"}, n, HOLD_N);
      check_val({tag, "_run_mode"}, bus.mode, M_RUN);
      check_val({tag, "_run_pc"}, bus.imem_addr, bus.cpu_pc);
      check_val({tag, "_run_words"}, bus.word_count, exp_words);
      if (inject_req) begin
         repeat (4) tick();
         check_val({tag, "_req_dropped"}, bus.mode, M_RUN);
         bus.load_request = 1'b0;
      end
      repeat (3) tick();
   endtask

   // Finish the load; the write attempted during HOLD_RESET must be blocked.
   task automatic finish_load(input string tag);
      bus.loader_state = 3'd4;
      bus.loader_wr    = 1'b0;
      tick();
      bus.loader_wr = 1'b1;
      #1;
      check_val({tag, "_fin_mode"}, bus.mode, M_HOLD);
      check_val({tag, "_fin_wr_blocked"}, bus.imem_wr, 0);
      check_val({tag, "_fin_ldr_en"}, bus.loader_enable, 0);
      bus.loader_wr    = 1'b0;
      bus.loader_state = 3'd0;
      wait_hold(tag, 1'b1);
   endtask

   // Loader reports an error; FAULT until the next request.
   task automatic fault_load(input string tag);
      bus.loader_state = 3'd6;
      tick();
      bus.loader_wr    = 1'b1;
      bus.loader_state = 3'd0;
      #1;
      check_val({tag, "_fault_mode"}, bus.mode, M_FAULT);
      check_val({tag, "_fault_error"}, bus.error, 1);
      check_val({tag, "_fault_cpu_reset"}, bus.cpu_reset, 1);
      check_val({tag, "_fault_wr"}, bus.imem_wr, 0);
      check_val({tag, "_fault_words"}, bus.word_count, exp_words);
      bus.loader_wr = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      reset            = 1'b1;
      bus.load_request = 1'b0;
      bus.loader_state = 3'd0;
      bus.loader_wr    = 1'b1;
      bus.loader_addr  = $urandom;
      bus.loader_data  = $urandom;
      bus.cpu_pc       = 32'h0000_0040;
      repeat (3) tick();
      check_val("rst_mode", bus.mode, M_HOLD);
      check_val("rst_cpu_reset", bus.cpu_reset, 1);
      check_val("rst_ldr_en", bus.loader_enable, 0);
      check_val("rst_wr", bus.imem_wr, 0);
      check_val("rst_error", bus.error, 0);
      check_val("rst_words", bus.word_count, 0);

      bus.loader_wr = 1'b0;
      reset         = 1'b0;
      wait_hold("por", 1'b0);
      check_val("por_cpu_reset", bus.cpu_reset, 0);
      check_val("por_pc40", bus.imem_addr, 32'h0000_0040);
      check_val("por_wdata", bus.imem_wdata, 0);

      for (int r = 0; r < 4; r++) begin
         if (r > 0) begin
            bus.cpu_pc = $urandom;
         end
         #1;
         check_val("run_pc", bus.imem_addr, bus.cpu_pc);
         check_val("run_wr", bus.imem_wr, 0);
         request_to_load("rnd");
         do_writes("rnd", (r == 0) ? 1 : $urandom_range(1, 6), r == 0);
         if (r == 1 || $urandom_range(0, 1) == 1) begin
            fault_load("rnd");
            request_to_load("refault");
            do_writes("refault", $urandom_range(1, 4), 1'b0);
         end
         finish_load("rnd");
      end

      // Timeout: a write at idle cycle 99 restarts the count, then 100 idle cycles fault.
      request_to_load("tmo");
      bus.loader_state = 3'd2;
      bus.loader_wr    = 1'b0;
      repeat (98) tick();
      bus.loader_wr = 1'b1;
      tick();
      exp_words++;
      bus.loader_wr = 1'b0;
      repeat (99) tick();
      check_val("tmo_no_fault_99", bus.mode, M_LOAD);
      tick();
      check_val("tmo_fault_100", bus.mode, M_FAULT);
      check_val("tmo_error", bus.error, 1);
      check_val("tmo_words", bus.word_count, exp_words);
      bus.loader_state = 3'd0;
      repeat (2) tick();
      request_to_load("tmo_rec");
      finish_load("tmo_rec");

      // Reset asserted in the middle of a load takes effect at once.
      request_to_load("mid");
      do_writes("mid", $urandom_range(1, 4), 1'b0);
      bus.loader_state = 3'd2;
      bus.loader_wr    = 1'b1;
      #1;
      reset = 1'b1;
      #1;
      check_val("mid_rst_ldr_en", bus.loader_enable, 0);
      check_val("mid_rst_wr", bus.imem_wr, 0);
      check_val("mid_rst_cpu_reset", bus.cpu_reset, 1);
      check_val("mid_rst_words", bus.word_count, 0);
      check_val("mid_rst_mode", bus.mode, M_HOLD);
      tick();
      bus.loader_wr    = 1'b0;
      bus.loader_state = 3'd0;
      reset            = 1'b0;
      exp_words        = 0;
      wait_hold("mid_rel", 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
